// File: rtl/proc_pkg.sv
// Shared definitions for the fetch-side hazard response logic.
//   state_t      : fetch FSM encodings (RUN / STALL / REDIRECT)
//   NOP_INST_DEF : default squash encoding for the IF/ID register
//   START_PC_DEF : default fetch PC after reset
//   PC_INC       : sequential fetch increment
package proc_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam logic [31:0] START_PC_DEF = 32'h0000_0040;
    localparam int          PC_INC       = 4;

endpackage

// File: rtl/fetch_hazard_resp_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
// Ports:
//   clk     : clock, rising-edge updates
//   reset_n : synchronous active-low clear
//   inc     : count this cycle
//   count   : current count (registered)
module sat_counter #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/fetch_hazard_resp.sv
// Fetch PC and IF/ID register owner; applies hazard-unit stall/flush and
// taken-branch redirect requests, and keeps stall/flush event counters.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   RUN      | normal sequential fetch
//   STALL    | previous edge applied a stall; PC and IF/ID are held
//   REDIRECT | previous edge redirected; fetching at branch target
//
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   stall, flush, take_br : hazard requests (priority take_br > stall > flush)
//   br_target             : redirect address used when take_br=1
//   imem_inst             : instruction read combinationally at pc_out
//   pc_out                : fetch PC
//   id_inst/id_pc/id_valid: IF/ID register contents (id_pc is PC+4)
//   ex_bubble             : ID/EX must load a NOP this cycle
//   state_out             : FSM state for debug
//   stall_cnt/flush_cnt   : saturating event counters
module fetch_hazard_resp
    import proc_pkg::*;
#(
    parameter int                   DBITS     = 32,
    parameter int                   INST_BITS = 32,
    parameter logic [DBITS-1:0]     START_PC  = DBITS'(START_PC_DEF),
    parameter logic [INST_BITS-1:0] NOP_INST  = INST_BITS'(NOP_INST_DEF),
    parameter int                   CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 take_br,
    input  logic [DBITS-1:0]     br_target,
    input  logic [INST_BITS-1:0] imem_inst,
    output logic [DBITS-1:0]     pc_out,
    output logic [INST_BITS-1:0] id_inst,
    output logic [DBITS-1:0]     id_pc,
    output logic                 id_valid,
    output logic                 ex_bubble,
    output logic [1:0]           state_out,
    output logic [CNT_BITS-1:0]  stall_cnt,
    output logic [CNT_BITS-1:0]  flush_cnt
);

    state_t                 state_q, state_d;
    logic [DBITS-1:0]       pc_d, id_pc_d, pc_inc;
    logic [INST_BITS-1:0]   id_inst_d;
    logic                   id_valid_d;
    logic                   stall_inc, flush_inc;

    // Wraps modulo 2^DBITS by construction.
    assign pc_inc = pc_out + DBITS'(PC_INC);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            pc_out   <= START_PC;
            id_inst  <= NOP_INST;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_out   <= pc_d;
            id_inst  <= id_inst_d;
            id_pc    <= id_pc_d;
            id_valid <= id_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_out;
        id_inst_d  = id_inst;
        id_pc_d    = id_pc;
        id_valid_d = id_valid;
        if (take_br) begin
            pc_d       = br_target;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            state_d    = ST_REDIRECT;
        end else if (stall) begin
            // Flush is deliberately ignored here: the stalled instruction
            // has to survive the load-use wait.
            state_d = ST_STALL;
        end else if (flush) begin
            pc_d       = pc_inc;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else begin
            pc_d       = pc_inc;
            id_inst_d  = imem_inst;
            id_pc_d    = pc_inc;
            id_valid_d = 1'b1;
            state_d    = ST_RUN;
        end
    end

    assign ex_bubble = reset_n & (stall | take_br);
    assign state_out = state_q;

    assign stall_inc = stall & ~take_br;
    assign flush_inc = take_br | (flush & ~stall);

    sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(.CNT_BITS(CNT_BITS)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_inc),
        .count   (flush_cnt)
    );

endmodule

// File: tb/tb_fetch_hazard_resp.sv
module tb_fetch_hazard_resp;

    logic        clk = 1'b0;
    logic        reset_n, stall, flush, take_br;
    logic [31:0] br_target, imem_inst;

    logic [31:0] pc_out, id_inst, id_pc;
    logic        id_valid, ex_bubble;
    logic [1:0]  state_out;
    logic [15:0] stall_cnt, flush_cnt;

    // narrow-counter copy used to reach saturation in a few cycles
    logic [31:0] s_pc_out, s_id_inst, s_id_pc;
    logic        s_id_valid, s_ex_bubble;
    logic [1:0]  s_state_out;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_hazard_resp dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .take_br(take_br), .br_target(br_target), .imem_inst(imem_inst),
        .pc_out(pc_out), .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid),
        .ex_bubble(ex_bubble), .state_out(state_out),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_hazard_resp #(.CNT_BITS(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .take_br(take_br), .br_target(br_target), .imem_inst(imem_inst),
        .pc_out(s_pc_out), .id_inst(s_id_inst), .id_pc(s_id_pc), .id_valid(s_id_valid),
        .ex_bubble(s_ex_bubble), .state_out(s_state_out),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_regs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic [31:0] e_idpc, input logic e_valid, input logic [1:0] e_st,
                              input int e_sc, input int e_fc);
        chk({tag, ".pc"},    pc_out,    e_pc);
        chk({tag, ".inst"},  id_inst,   e_inst);
        chk({tag, ".id_pc"}, id_pc,     e_idpc);
        chk({tag, ".valid"}, id_valid,  e_valid);
        chk({tag, ".state"}, state_out, e_st);
        chk({tag, ".scnt"},  stall_cnt, sat(e_sc, 16'hFFFF));
        chk({tag, ".fcnt"},  flush_cnt, sat(e_fc, 16'hFFFF));
        chk({tag, ".s_scnt"}, s_stall_cnt, sat(e_sc, 3));
        chk({tag, ".s_fcnt"}, s_flush_cnt, sat(e_fc, 3));
    endtask

    typedef struct {
        logic        rn, st, fl, tb;
        logic [31:0] tgt, imem;
        logic        e_bub;
        logic [31:0] e_pc, e_inst, e_idpc;
        logic        e_valid;
        logic [1:0]  e_state;
        int          e_sc, e_fc;
    } vec_t;

    function automatic vec_t mk(input logic rn, input logic st, input logic fl, input logic tb,
                                input logic [31:0] tgt, input logic [31:0] imem, input logic bub,
                                input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] idpc,
                                input logic v, input logic [1:0] s, input int sc, input int fc);
        vec_t r;
        r.rn = rn; r.st = st; r.fl = fl; r.tb = tb; r.tgt = tgt; r.imem = imem;
        r.e_bub = bub; r.e_pc = pc; r.e_inst = inst; r.e_idpc = idpc;
        r.e_valid = v; r.e_state = s; r.e_sc = sc; r.e_fc = fc;
        return r;
    endfunction

    vec_t vt[16];

    // behavioural reference state
    logic [31:0] m_pc, m_inst, m_idpc;
    logic        m_valid;
    logic [1:0]  m_state;
    int          m_sc, m_fc;

    task automatic model_edge();
        if (!reset_n) begin
            m_pc = 32'h40; m_inst = 32'h0; m_idpc = 32'h0; m_valid = 1'b0;
            m_state = 2'd0; m_sc = 0; m_fc = 0;
        end else if (take_br) begin
            m_pc = br_target; m_inst = 32'h0; m_valid = 1'b0; m_state = 2'd2; m_fc++;
        end else if (stall) begin
            m_state = 2'd1; m_sc++;
        end else if (flush) begin
            m_pc = m_pc + 32'd4; m_inst = 32'h0; m_valid = 1'b0; m_state = 2'd0; m_fc++;
        end else begin
            m_inst = imem_inst; m_idpc = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            m_valid = 1'b1; m_state = 2'd0;
        end
    endtask

    task automatic drive(input logic rn, input logic st, input logic fl, input logic tb,
                         input logic [31:0] tgt, input logic [31:0] imem);
        reset_n = rn; stall = st; flush = fl; take_br = tb; br_target = tgt; imem_inst = imem;
    endtask

    initial begin
        string tag;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("reset.bub", ex_bubble, 1'b0);
        check_regs("reset", 32'h40, 32'h0, 32'h0, 1'b0, 2'd0, 0, 0);

        //       rn st fl tb  target        imem          bub pc            inst          id_pc         v  st  sc fc
        vt[0]  = mk(1, 0, 0, 0, 32'h0,        32'hA0,       0, 32'h44,       32'hA0,       32'h44,       1, 0, 0, 0);
        vt[1]  = mk(1, 0, 0, 0, 32'h0,        32'hA1,       0, 32'h48,       32'hA1,       32'h48,       1, 0, 0, 0);
        vt[2]  = mk(1, 1, 1, 0, 32'h0,        32'hA2,       1, 32'h48,       32'hA1,       32'h48,       1, 1, 1, 0);
        vt[3]  = mk(1, 1, 1, 0, 32'h0,        32'hA2,       1, 32'h48,       32'hA1,       32'h48,       1, 1, 2, 0);
        vt[4]  = mk(1, 0, 0, 0, 32'h0,        32'hA2,       0, 32'h4C,       32'hA2,       32'h4C,       1, 0, 2, 0);
        vt[5]  = mk(1, 0, 0, 0, 32'h0,        32'hA3,       0, 32'h50,       32'hA3,       32'h50,       1, 0, 2, 0);
        vt[6]  = mk(1, 0, 0, 1, 32'h100,      32'hA4,       1, 32'h100,      32'h0,        32'h50,       0, 2, 2, 1);
        vt[7]  = mk(1, 0, 0, 0, 32'h0,        32'hB0,       0, 32'h104,      32'hB0,       32'h104,      1, 0, 2, 1);
        vt[8]  = mk(1, 1, 0, 1, 32'h200,      32'hB1,       1, 32'h200,      32'h0,        32'h104,      0, 2, 2, 2);
        vt[9]  = mk(1, 0, 1, 0, 32'h0,        32'hB2,       0, 32'h204,      32'h0,        32'h104,      0, 0, 2, 3);
        vt[10] = mk(1, 1, 0, 0, 32'h0,        32'hB3,       1, 32'h204,      32'h0,        32'h104,      0, 1, 3, 3);
        vt[11] = mk(0, 1, 0, 0, 32'h0,        32'hB4,       0, 32'h40,       32'h0,        32'h0,        0, 0, 0, 0);
        vt[12] = mk(1, 0, 0, 1, 32'hFFFFFFFC, 32'hB5,       1, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 2, 0, 1);
        vt[13] = mk(1, 0, 0, 0, 32'h0,        32'hC0,       0, 32'h0,        32'hC0,       32'h0,        1, 0, 0, 1);
        vt[14] = mk(1, 0, 0, 1, 32'h300,      32'hC1,       1, 32'h300,      32'h0,        32'h0,        0, 2, 0, 2);
        vt[15] = mk(1, 1, 0, 0, 32'h0,        32'hC2,       1, 32'h300,      32'h0,        32'h0,        0, 1, 1, 2);

        for (int i = 0; i < 16; i++) begin
            tag = $sformatf("vec%0d", i);
            drive(vt[i].rn, vt[i].st, vt[i].fl, vt[i].tb, vt[i].tgt, vt[i].imem);
            #1;
            chk({tag, ".bub"}, ex_bubble, vt[i].e_bub);
            @(posedge clk); #1;
            check_regs(tag, vt[i].e_pc, vt[i].e_inst, vt[i].e_idpc, vt[i].e_valid,
                       vt[i].e_state, vt[i].e_sc, vt[i].e_fc);
        end

        // long stall run: narrow counter must stick at all-ones, wide keeps counting
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hD0);
            @(posedge clk); #1;
            chk($sformatf("sat%0d.s_scnt", i), s_stall_cnt, sat(i, 3));
            chk($sformatf("sat%0d.scnt", i), stall_cnt, i);
            chk($sformatf("sat%0d.pc", i), pc_out, 32'h40);
        end

        // randomized traffic against the reference model
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_edge();
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
                  $urandom & 32'hFFFF_FFFC, $urandom);
            #1;
            tag = $sformatf("rnd%0d", i);
            chk({tag, ".bub"}, ex_bubble, reset_n && (stall || take_br));
            model_edge();
            @(posedge clk); #1;
            check_regs(tag, m_pc, m_inst, m_idpc, m_valid, m_state, m_sc, m_fc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
